// File: rtl/run_monitor_if.sv
// Observation bus between the CPU-side driver and run_monitor.
// master drives the PC/result stream and clear; slave returns run status.
interface run_monitor_if #(
  parameter int unsigned ADDRESS_WIDTH = 32,
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned COUNT_WIDTH   = 32
);
  logic [ADDRESS_WIDTH-1:0] pcw;
  logic [DATA_WIDTH-1:0]    result;
  logic                     clear;
  logic                     done;
  logic                     timed_out;
  logic [COUNT_WIDTH-1:0]   cycle_count;
  logic [COUNT_WIDTH-1:0]   pc_changes;
  logic [DATA_WIDTH-1:0]    signature;
  logic [ADDRESS_WIDTH-1:0] halt_pc;

  modport master (
    output pcw, result, clear,
    input  done, timed_out, cycle_count, pc_changes, signature, halt_pc
  );

  modport slave (
    input  pcw, result, clear,
    output done, timed_out, cycle_count, pc_changes, signature, halt_pc
  );
endinterface

// File: rtl/run_monitor.sv
// Detects program halt (PC held constant), counts cycles/PC changes and folds results into a
// signature. Define RUN_MONITOR_TIMEOUT_EN to build the runaway-program timeout.
module run_monitor #(
  parameter int unsigned ADDRESS_WIDTH  = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned COUNT_WIDTH    = 32,
  parameter int unsigned HALT_CYCLES    = 4,
  parameter int unsigned TIMEOUT_CYCLES = 200
) (
  input logic         clk,
  input logic         rst,
  run_monitor_if.slave mon
);

  localparam int unsigned StreakWidth = $clog2(HALT_CYCLES + 1);
  localparam logic [StreakWidth-1:0] HaltCount = StreakWidth'(HALT_CYCLES);

  if (DATA_WIDTH < 2) begin : gen_bad_data_width
    $error("run_monitor: DATA_WIDTH must be at least 2");
  end
  if (HALT_CYCLES < 1) begin : gen_bad_halt_cycles
    $error("run_monitor: HALT_CYCLES must be at least 1");
  end
  if (TIMEOUT_CYCLES < 1) begin : gen_bad_timeout_cycles
    $error("run_monitor: TIMEOUT_CYCLES must be at least 1");
  end

`ifdef RUN_MONITOR_TIMEOUT_EN
  localparam logic [COUNT_WIDTH-1:0] TimeoutCount = COUNT_WIDTH'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    StWait,
    StRun,
    StDone,
    StTimeout
  } state_e;
`else
  typedef enum logic [1:0] {
    StWait,
    StRun,
    StDone
  } state_e;
`endif

  state_e                   state_q, state_d;
  logic [ADDRESS_WIDTH-1:0] prev_pc_q, prev_pc_d;
  logic [StreakWidth-1:0]   streak_q, streak_d;
  logic [COUNT_WIDTH-1:0]   cycle_count_q, cycle_count_d;
  logic [COUNT_WIDTH-1:0]   pc_changes_q, pc_changes_d;
  logic [DATA_WIDTH-1:0]    signature_q, signature_d;
  logic [ADDRESS_WIDTH-1:0] halt_pc_q, halt_pc_d;

  logic [COUNT_WIDTH-1:0]   cycle_inc;
  logic [COUNT_WIDTH-1:0]   pc_changes_inc;
  logic [StreakWidth-1:0]   streak_inc;
  logic                     halt;

  always_comb begin
    state_d       = state_q;
    prev_pc_d     = prev_pc_q;
    streak_d      = streak_q;
    cycle_count_d = cycle_count_q;
    pc_changes_d  = pc_changes_q;
    signature_d   = signature_q;
    halt_pc_d     = halt_pc_q;
    halt          = 1'b0;

    cycle_inc      = (cycle_count_q == '1) ? cycle_count_q : cycle_count_q + COUNT_WIDTH'(1);
    pc_changes_inc = (pc_changes_q == '1) ? pc_changes_q : pc_changes_q + COUNT_WIDTH'(1);
    streak_inc     = streak_q + StreakWidth'(1);

    if (mon.clear) begin
      state_d       = StWait;
      prev_pc_d     = '0;
      streak_d      = '0;
      cycle_count_d = '0;
      pc_changes_d  = '0;
      signature_d   = '0;
      halt_pc_d     = '0;
    end else begin
      unique case (state_q)
        StWait: begin
          prev_pc_d = mon.pcw;
          state_d   = StRun;
        end
        StRun: begin
          cycle_count_d = cycle_inc;
          if (mon.pcw != prev_pc_q) begin
            pc_changes_d = pc_changes_inc;
            signature_d  = {signature_q[DATA_WIDTH-2:0], signature_q[DATA_WIDTH-1]} ^ mon.result;
            prev_pc_d    = mon.pcw;
            streak_d     = '0;
          end else begin
            streak_d = streak_inc;
            if (streak_inc == HaltCount) begin
              halt      = 1'b1;
              state_d   = StDone;
              halt_pc_d = mon.pcw;
            end
          end
`ifdef RUN_MONITOR_TIMEOUT_EN
          // A halt on the budget's last edge takes precedence over the timeout.
          if (!halt && (cycle_inc == TimeoutCount)) begin
            state_d = StTimeout;
          end
`endif
        end
        default: begin
          // Terminal states hold every register until rst or clear.
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StWait;
      prev_pc_q     <= '0;
      streak_q      <= '0;
      cycle_count_q <= '0;
      pc_changes_q  <= '0;
      signature_q   <= '0;
      halt_pc_q     <= '0;
    end else begin
      state_q       <= state_d;
      prev_pc_q     <= prev_pc_d;
      streak_q      <= streak_d;
      cycle_count_q <= cycle_count_d;
      pc_changes_q  <= pc_changes_d;
      signature_q   <= signature_d;
      halt_pc_q     <= halt_pc_d;
    end
  end

  assign mon.done        = (state_q == StDone);
`ifdef RUN_MONITOR_TIMEOUT_EN
  assign mon.timed_out   = (state_q == StTimeout);
`else
  assign mon.timed_out   = 1'b0;
`endif
  assign mon.cycle_count = cycle_count_q;
  assign mon.pc_changes  = pc_changes_q;
  assign mon.signature   = signature_q;
  assign mon.halt_pc     = halt_pc_q;

endmodule

// File: tb/tb_run_monitor.sv
// Self-checking bench for run_monitor: spec-level reference model feeding a scoreboard queue,
// plus fixed expected values for each scenario.
module tb_run_monitor;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned CW = 32;
  localparam int unsigned HALT = 4;
  localparam int unsigned TIMEOUT = 200;

  typedef struct packed {
    logic          done;
    logic          timed_out;
    logic [CW-1:0] cycle_count;
    logic [CW-1:0] pc_changes;
    logic [DW-1:0] signature;
    logic [AW-1:0] halt_pc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  run_monitor_if #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .COUNT_WIDTH(CW)) mon_if ();

  run_monitor #(
    .ADDRESS_WIDTH (AW),
    .DATA_WIDTH    (DW),
    .COUNT_WIDTH   (CW),
    .HALT_CYCLES   (HALT),
    .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .mon(mon_if)
  );

  always #5 clk = ~clk;

  // Reference model state: 0 WAIT, 1 RUN, 2 DONE, 3 TIMEOUT.
  int            m_state = 0;
  logic [AW-1:0] m_prev = '0;
  int            m_streak = 0;
  exp_t          m;
  exp_t          sb[$];

  task automatic model_edge(input logic rs, input logic clr, input logic [AW-1:0] pc,
                            input logic [DW-1:0] res);
    bit halt;
    halt = 1'b0;
    if (rs || clr) begin
      m_state = 0;
      m_prev = '0;
      m_streak = 0;
      m = '0;
    end else if (m_state == 0) begin
      m_prev = pc;
      m_state = 1;
    end else if (m_state == 1) begin
      if (m.cycle_count != '1) m.cycle_count = m.cycle_count + 1;
      if (pc != m_prev) begin
        if (m.pc_changes != '1) m.pc_changes = m.pc_changes + 1;
        m.signature = {m.signature[DW-2:0], m.signature[DW-1]} ^ res;
        m_prev = pc;
        m_streak = 0;
      end else begin
        m_streak++;
        if (m_streak == HALT) begin
          halt = 1'b1;
          m_state = 2;
          m.done = 1'b1;
          m.halt_pc = pc;
        end
      end
`ifdef RUN_MONITOR_TIMEOUT_EN
      if (!halt && m.cycle_count == TIMEOUT) begin
        m_state = 3;
        m.timed_out = 1'b1;
      end
`endif
    end
  endtask

  // Drive one edge's inputs, queue the model's expectation, then compare after the edge.
  task automatic clock_edge(input logic rs, input logic clr, input logic [AW-1:0] pc,
                            input logic [DW-1:0] res, input string tag);
    exp_t e;
    exp_t got;
    rst = rs;
    mon_if.clear = clr;
    mon_if.pcw = pc;
    mon_if.result = res;
    model_edge(rs, clr, pc, res);
    sb.push_back(m);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    got = {mon_if.done, mon_if.timed_out, mon_if.cycle_count, mon_if.pc_changes,
           mon_if.signature, mon_if.halt_pc};
    checks++;
    if (got !== e) begin
      failures++;
      $display("FAIL %s: got done=%b to=%b cc=%0d pcc=%0d sig=%h hpc=%h, need done=%b to=%b cc=%0d pcc=%0d sig=%h hpc=%h",
               tag, got.done, got.timed_out, got.cycle_count, got.pc_changes, got.signature,
               got.halt_pc, e.done, e.timed_out, e.cycle_count, e.pc_changes, e.signature,
               e.halt_pc);
    end
  endtask

  // WAIT edge at pc 0, then 4, 8, 12 and four more 12s; halt lands on RUN edge 7.
  task automatic run_halt_seq(input logic [DW-1:0] r1, input logic [DW-1:0] r2,
                              input logic [DW-1:0] r3, input string tag);
    logic [AW-1:0] pcs[8];
    logic [DW-1:0] res;
    pcs = '{32'd0, 32'd4, 32'd8, 32'd12, 32'd12, 32'd12, 32'd12, 32'd12};
    for (int i = 0; i < 8; i++) begin
      res = (i == 1) ? r1 : (i == 2) ? r2 : (i == 3) ? r3 : $urandom;
      clock_edge(1'b0, 1'b0, pcs[i], res, tag);
    end
    checks++;
    if (mon_if.done !== 1'b1 || mon_if.timed_out !== 1'b0 || mon_if.cycle_count !== 32'd7 ||
        mon_if.pc_changes !== 32'd3 || mon_if.halt_pc !== 32'd12) begin
      failures++;
      $display("FAIL %s_final: done=%b to=%b cc=%0d pcc=%0d hpc=%0d, need 1 0 7 3 12", tag,
               mon_if.done, mon_if.timed_out, mon_if.cycle_count, mon_if.pc_changes,
               mon_if.halt_pc);
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) clock_edge(1'b1, 1'b0, $urandom, $urandom, "reset_hold");
    clock_edge(1'b0, 1'b0, 32'h40, $urandom, "reset_wait_edge");
    checks++;
    if (mon_if.cycle_count !== 32'd0 || mon_if.done !== 1'b0) begin
      failures++;
      $display("FAIL reset_wait: cc=%0d done=%b, need 0 0", mon_if.cycle_count, mon_if.done);
    end
    clock_edge(1'b0, 1'b0, 32'h44, $urandom, "reset_first_run");
    checks++;
    if (mon_if.cycle_count !== 32'd1 || mon_if.pc_changes !== 32'd1) begin
      failures++;
      $display("FAIL reset_first_run: cc=%0d pcc=%0d, need 1 1", mon_if.cycle_count,
               mon_if.pc_changes);
    end
  endtask

  task automatic test_halt();
    logic [CW-1:0] cc;
    logic [DW-1:0] sig;
    clock_edge(1'b1, 1'b0, '0, '0, "halt_rst");
    run_halt_seq($urandom, $urandom, $urandom, "halt");
    cc = mon_if.cycle_count;
    sig = mon_if.signature;
    for (int i = 0; i < 10; i++) begin
      clock_edge(1'b0, 1'b0, 32'h100 + 4 * i, $urandom, "halt_freeze");
      checks++;
      if (mon_if.done !== 1'b1 || mon_if.cycle_count !== 32'd7 || mon_if.pc_changes !== 32'd3 ||
          mon_if.halt_pc !== 32'd12 || mon_if.signature !== sig || cc !== 32'd7) begin
        failures++;
        $display("FAIL halt_frozen: done=%b cc=%0d pcc=%0d hpc=%0d sig=%h, need 1 7 3 12 %h",
                 mon_if.done, mon_if.cycle_count, mon_if.pc_changes, mon_if.halt_pc,
                 mon_if.signature, sig);
      end
    end
  endtask

  task automatic test_signature();
    clock_edge(1'b1, 1'b0, '0, '0, "sig_rst");
    run_halt_seq(32'd1, 32'd2, 32'd3, "sig");
    checks++;
    if (mon_if.signature !== 32'd3) begin
      failures++;
      $display("FAIL signature: got %h need 00000003", mon_if.signature);
    end
  endtask

  task automatic test_timeout();
    clock_edge(1'b1, 1'b0, '0, '0, "to_rst");
    clock_edge(1'b0, 1'b0, '0, $urandom, "to_wait");
`ifdef RUN_MONITOR_TIMEOUT_EN
    for (int i = 1; i <= 200; i++) clock_edge(1'b0, 1'b0, 4 * i, $urandom, "to_run");
    checks++;
    if (mon_if.timed_out !== 1'b1 || mon_if.done !== 1'b0 || mon_if.cycle_count !== 32'd200 ||
        mon_if.pc_changes !== 32'd200) begin
      failures++;
      $display("FAIL timeout: to=%b done=%b cc=%0d pcc=%0d, need 1 0 200 200", mon_if.timed_out,
               mon_if.done, mon_if.cycle_count, mon_if.pc_changes);
    end
    for (int i = 201; i <= 205; i++) clock_edge(1'b0, 1'b0, 4 * i, $urandom, "to_freeze");
    checks++;
    if (mon_if.cycle_count !== 32'd200 || mon_if.timed_out !== 1'b1) begin
      failures++;
      $display("FAIL timeout_frozen: cc=%0d to=%b, need 200 1", mon_if.cycle_count,
               mon_if.timed_out);
    end
`else
    for (int i = 1; i <= 1000; i++) clock_edge(1'b0, 1'b0, 4 * i, $urandom, "noto_run");
    checks++;
    if (mon_if.timed_out !== 1'b0 || mon_if.done !== 1'b0 || mon_if.cycle_count !== 32'd1000) begin
      failures++;
      $display("FAIL no_timeout: to=%b done=%b cc=%0d, need 0 0 1000", mon_if.timed_out,
               mon_if.done, mon_if.cycle_count);
    end
`endif
  endtask

  task automatic test_tie();
    clock_edge(1'b1, 1'b0, '0, '0, "tie_rst");
    clock_edge(1'b0, 1'b0, '0, $urandom, "tie_wait");
    for (int i = 1; i <= 196; i++) clock_edge(1'b0, 1'b0, 4 * i, $urandom, "tie_run");
    for (int i = 197; i <= 200; i++) clock_edge(1'b0, 1'b0, 32'd784, $urandom, "tie_hold");
    checks++;
    if (mon_if.done !== 1'b1 || mon_if.timed_out !== 1'b0 || mon_if.cycle_count !== 32'd200 ||
        mon_if.pc_changes !== 32'd196 || mon_if.halt_pc !== 32'd784) begin
      failures++;
      $display("FAIL tie: done=%b to=%b cc=%0d pcc=%0d hpc=%0d, need 1 0 200 196 784",
               mon_if.done, mon_if.timed_out, mon_if.cycle_count, mon_if.pc_changes,
               mon_if.halt_pc);
    end
  endtask

  task automatic test_abort();
    logic rs;
    logic clr;
    for (int v = 0; v < 3; v++) begin
      rs = (v != 0);
      clr = (v != 1);
      clock_edge(1'b1, 1'b0, '0, '0, "abort_rst");
      clock_edge(1'b0, 1'b0, '0, $urandom, "abort_wait");
      for (int i = 1; i < 50; i++) clock_edge(1'b0, 1'b0, 4 * i, $urandom, "abort_run");
      clock_edge(rs, clr, 32'd200, $urandom, "abort_pulse");
      checks++;
      if (mon_if.cycle_count !== '0 || mon_if.pc_changes !== '0 || mon_if.signature !== '0 ||
          mon_if.done !== 1'b0) begin
        failures++;
        $display("FAIL abort_clear v%0d: cc=%0d pcc=%0d sig=%h done=%b, need all 0", v,
                 mon_if.cycle_count, mon_if.pc_changes, mon_if.signature, mon_if.done);
      end
      run_halt_seq(32'd1, 32'd2, 32'd3, "abort_halt");
      checks++;
      if (mon_if.signature !== 32'd3) begin
        failures++;
        $display("FAIL abort_sig v%0d: got %h need 00000003", v, mon_if.signature);
      end
    end
  endtask

  initial begin
    mon_if.clear = 1'b0;
    mon_if.pcw = '0;
    mon_if.result = '0;
    test_reset();
    test_halt();
    test_signature();
    test_timeout();
    test_tie();
    test_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
